// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq: PLL lock supervisor and ordered reset sequencer for the DSI-to-OLED pipeline.
// Build macro PLL_LOCK_DEGLITCH_EN: lock loss is acted on only after 4 consecutive low lock samples.
`timescale 1ns/1ps

module pll_lock_rst_seq #(
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int N_STAGES         = 3,
    parameter int STAGE_GAP_CYC    = 64,
    parameter int MAX_RETRY        = 4
) (
    input  logic                             CLKI,
    input  logic                             RST,
    input  logic                             pll_lock_i,
    output logic                             pll_rst_o,
    output logic [N_STAGES-1:0]              rst_stage_o,
    output logic                             ready_o,
    output logic                             lock_lost_o,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_o,
    output logic                             fault_o
);

    localparam int MAX_A   = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_B   = (LOCK_STABLE_CYC > STAGE_GAP_CYC) ? LOCK_STABLE_CYC : STAGE_GAP_CYC;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]    CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]    PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]    STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST     = CNT_W'(STAGE_GAP_CYC - 1);
    localparam logic [IDX_W-1:0]    IDX_FIRST    = IDX_W'(1);
    localparam logic [IDX_W-1:0]    IDX_LAST     = IDX_W'(N_STAGES - 1);
    localparam logic [RTY_W-1:0]    RTY_ONE      = RTY_W'(1);
    localparam logic [RTY_W-1:0]    RTY_MAX      = RTY_W'(MAX_RETRY);
    localparam logic [N_STAGES-1:0] STAGE_ALL    = '1;
    localparam logic [N_STAGES-1:0] STAGE_ONE    = N_STAGES'(1);
    localparam logic [N_STAGES-1:0] STAGE_FIRST  = STAGE_ALL << 1;

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_RETRY     = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    logic                r_lock_meta;
    logic                r_lock_s;
    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [RTY_W-1:0]    r_retry_cnt;
    logic [N_STAGES-1:0] r_rst_stage;
    logic                r_pll_rst;
    logic                r_ready;
    logic                r_fault;

    logic [2:0]          w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [RTY_W-1:0]    w_retry_nxt;
    logic [N_STAGES-1:0] w_stage_nxt;
    logic                w_go_release;
    logic                w_lock_drop;

    // Two-flop synchronizer for the PLL LOCK output, which is asynchronous to CLKI.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock_i;
            r_lock_s    <= r_lock_meta;
        end
    end

`ifdef PLL_LOCK_DEGLITCH_EN
    logic [1:0] r_low_cnt;
    logic       w_monitored;

    assign w_monitored = (r_state == ST_STABLE) || (r_state == ST_RELEASE) || (r_state == ST_RUN);

    always_ff @(posedge CLKI) begin
        if (RST) begin
            r_low_cnt <= 2'd0;
        end else if (w_monitored && !r_lock_s) begin
            r_low_cnt <= r_low_cnt + 2'd1;
        end else begin
            r_low_cnt <= 2'd0;
        end
    end

    assign w_lock_drop = !r_lock_s && (r_low_cnt == 2'd3);
`else
    assign w_lock_drop = !r_lock_s;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_retry_nxt  = r_retry_cnt;
        w_stage_nxt  = r_rst_stage;
        w_go_release = 1'b0;

        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == PLL_RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    // The cycle lock is first seen already counts as stable cycle one.
                    if (LOCK_STABLE_CYC == 1) begin
                        w_go_release = 1'b1;
                    end else begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = ST_RETRY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (w_lock_drop) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_lock_s) begin
                    if (r_cnt == STABLE_LAST) begin
                        w_go_release = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
            end
            ST_RELEASE: begin
                if (w_lock_drop) begin
                    w_state_nxt = ST_RETRY;
                    w_stage_nxt = STAGE_ALL;
                end else if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_stage_nxt = r_rst_stage & ~(STAGE_ONE << r_idx);
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_FIRST;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (w_lock_drop) begin
                    w_state_nxt = ST_RETRY;
                    w_stage_nxt = STAGE_ALL;
                end
            end
            ST_RETRY: begin
                w_stage_nxt = STAGE_ALL;
                w_cnt_nxt   = '0;
                if (r_retry_cnt == RTY_MAX) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_state_nxt = ST_PLL_RST;
                    w_retry_nxt = r_retry_cnt + RTY_ONE;
                end
            end
            ST_FAULT: begin
                w_stage_nxt = STAGE_ALL;
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
                w_cnt_nxt   = '0;
                w_stage_nxt = STAGE_ALL;
            end
        endcase

        // Stage 0 is released on the very first RELEASE cycle; a single stage means straight to RUN.
        if (w_go_release) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = IDX_FIRST;
            w_stage_nxt = STAGE_FIRST;
            if (N_STAGES == 1) begin
                w_state_nxt = ST_RUN;
                w_retry_nxt = '0;
            end else begin
                w_state_nxt = ST_RELEASE;
            end
        end
    end

    // NOTE: reset is synchronous and sampled inside the clocked block; outputs are registered
    // from next state so the PLL and downstream resets never see decode glitches.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_retry_cnt <= '0;
            r_rst_stage <= STAGE_ALL;
            r_pll_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_rst_stage <= w_stage_nxt;
            r_pll_rst   <= (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAULT);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_fault     <= (w_state_nxt == ST_FAULT);
        end
    end

    assign pll_rst_o   = r_pll_rst;
    assign rst_stage_o = r_rst_stage;
    assign ready_o     = r_ready;
    assign lock_lost_o = ((r_state == ST_RELEASE) || (r_state == ST_RUN)) && w_lock_drop;
    assign retry_cnt_o = r_retry_cnt;
    assign fault_o     = r_fault;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// tb_pll_lock_rst_seq: directed self-checking bench for pll_lock_rst_seq with small timing parameters.
// Cycle c is the c-th clock period after the last edge that sampled RST high.
`timescale 1ns/1ps

module tb_pll_lock_rst_seq;

    localparam int PLL_RST_CYC      = 4;
    localparam int LOCK_TIMEOUT_CYC = 32;
    localparam int LOCK_STABLE_CYC  = 8;
    localparam int N_STAGES         = 3;
    localparam int STAGE_GAP_CYC    = 2;
    localparam int MAX_RETRY        = 2;

`ifdef PLL_LOCK_DEGLITCH_EN
    localparam int T3_RELEASE = 21;
`else
    localparam int T3_RELEASE = 26;
`endif

    logic                CLKI = 1'b0;
    logic                RST;
    logic                pll_lock_i;
    logic                pll_rst_o;
    logic [N_STAGES-1:0] rst_stage_o;
    logic                ready_o;
    logic                lock_lost_o;
    logic [1:0]          retry_cnt_o;
    logic                fault_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLKI = ~CLKI;

    pll_lock_rst_seq #(
        .PLL_RST_CYC      (PLL_RST_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .N_STAGES         (N_STAGES),
        .STAGE_GAP_CYC    (STAGE_GAP_CYC),
        .MAX_RETRY        (MAX_RETRY)
    ) dut (
        .CLKI        (CLKI),
        .RST         (RST),
        .pll_lock_i  (pll_lock_i),
        .pll_rst_o   (pll_rst_o),
        .rst_stage_o (rst_stage_o),
        .ready_o     (ready_o),
        .lock_lost_o (lock_lost_o),
        .retry_cnt_o (retry_cnt_o),
        .fault_o     (fault_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLKI);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic expect_all(input string t, input int c, input logic pr, input logic [2:0] st,
                              input logic rd, input logic ll, input logic [1:0] rt, input logic ft);
        check($sformatf("%s c%0d pll_rst", t, c), 32'(pll_rst_o), 32'(pr));
        check($sformatf("%s c%0d rst_stage", t, c), 32'(rst_stage_o), 32'(st));
        check($sformatf("%s c%0d ready", t, c), 32'(ready_o), 32'(rd));
        check($sformatf("%s c%0d lock_lost", t, c), 32'(lock_lost_o), 32'(ll));
        check($sformatf("%s c%0d retry_cnt", t, c), 32'(retry_cnt_o), 32'(rt));
        check($sformatf("%s c%0d fault", t, c), 32'(fault_o), 32'(ft));
    endtask

    // Release staircase starting at cycle r: 111 before, then 110, 100, 000 two cycles apart.
    function automatic logic [2:0] rel_stage(input int c, input int r);
        if (c < r)          return 3'b111;
        else if (c < r + 2) return 3'b110;
        else if (c < r + 4) return 3'b100;
        else                return 3'b000;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b0;
        pll_lock_i = 1'b0;

        // T1: lock from cycle 10, lock_s at 12, 8 stable cycles 12..19, release 20..24.
        do_reset();
        for (int c = 0; c < 28; c++) begin
            if (c == 10) pll_lock_i = 1'b1;
            expect_all("t1", c, c <= 3, rel_stage(c, 20), c >= 24, 1'b0, 2'd0, 1'b0);
            tick();
        end

`ifndef PLL_LOCK_DEGLITCH_EN
        // T2: one-cycle dip in RUN; lock_s low in cycle 30, retry, re-lock, RUN again at 48.
        for (int c = 28; c <= 50; c++) begin
            if (c == 28) pll_lock_i = 1'b0;
            if (c == 29) pll_lock_i = 1'b1;
            expect_all("t2", c, (c >= 32) && (c <= 35),
                       (c <= 30) ? 3'b000 : rel_stage(c, 44),
                       (c <= 30) || (c >= 48), c == 30,
                       ((c >= 32) && (c <= 47)) ? 2'd1 : 2'd0, 1'b0);
            tick();
        end
`else
        // T2 deglitch: 3-cycle dip ignored; 4-cycle dip (lock_s low 36..39) acts at cycle 39.
        for (int c = 28; c <= 42; c++) begin
            if (c == 28) pll_lock_i = 1'b0;
            if (c == 31) pll_lock_i = 1'b1;
            if (c == 34) pll_lock_i = 1'b0;
            if (c == 38) pll_lock_i = 1'b1;
            expect_all("t2d", c, c >= 41, (c >= 40) ? 3'b111 : 3'b000, c <= 39, c == 39,
                       (c >= 41) ? 2'd1 : 2'd0, 1'b0);
            tick();
        end
`endif

        // T3: lock_s drops for one cycle at stable count 5; a fresh 8-cycle run is needed.
        pll_lock_i = 1'b0;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            if (c == 10) pll_lock_i = 1'b1;
            if (c == 15) pll_lock_i = 1'b0;
            if (c == 16) pll_lock_i = 1'b1;
            expect_all("t3", c, c <= 3, rel_stage(c, T3_RELEASE), c >= T3_RELEASE + 4,
                       1'b0, 2'd0, 1'b0);
            tick();
        end

        // T4: RST during RELEASE with stages at 100 aborts to reset values at the next edge.
        pll_lock_i = 1'b0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            if (c == 10) pll_lock_i = 1'b1;
            tick();
        end
        check("t4 stage before abort", 32'(rst_stage_o), 32'(3'b100));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        expect_all("t4 abort", 0, 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 1'b0);
        // Lock stays high through the abort; the synchronizer restarts from zero.
        for (int c = 0; c < 18; c++) begin
            expect_all("t4 relock", c, c <= 3, rel_stage(c, 12), c >= 16, 1'b0, 2'd0, 1'b0);
            tick();
        end

        // T5: lock never asserts: three 4-cycle PLL resets, then sticky fault; lock ignored there.
        pll_lock_i = 1'b0;
        do_reset();
        for (int c = 0; c <= 120; c++) begin
            if (c == 115) pll_lock_i = 1'b1;
            expect_all("t5", c,
                       (c <= 3) || ((c >= 37) && (c <= 40)) || ((c >= 74) && (c <= 77)) || (c >= 111),
                       3'b111, 1'b0, 1'b0,
                       (c < 37) ? 2'd0 : (c < 74) ? 2'd1 : 2'd2, c >= 111);
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        expect_all("t5 clear", 0, 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_rst_seq.md
Name: pll_lock_rst_seq

Overview:
- Lock supervisor and reset sequencer directly downstream of the CrossLink PLL primitive.
- Drives the PLL's RST input and consumes its asynchronous LOCK output.
- Releases the per-domain resets of the DSI-to-OLED pipeline in order, only after lock has been stable for a qualified time.
- On lock loss or lock timeout: re-resets the PLL and retries; after too many failures, enters a sticky fault.

Parameters:
- PLL_RST_CYC, 16: cycles pll_rst_o is held high per PLL reset attempt (>=1).
- LOCK_TIMEOUT_CYC, 65536: max cycles spent in WAIT_LOCK before a retry.
- LOCK_STABLE_CYC, 1024: consecutive synchronized-lock cycles required before release (>=1).
- N_STAGES, 3: number of sequenced downstream resets (>=1).
- STAGE_GAP_CYC, 64: cycles between successive stage releases (>=1).
- MAX_RETRY, 4: retries allowed before FAULT.

Ports:
- CLKI  in  1  free-running reference clock; same source as the PLL input, never the PLL output.
- RST  in  1  synchronous, active-high reset.
- pll_lock_i  in  1  PLL LOCK; asynchronous to CLKI.
- pll_rst_o  out  1  to PLL RST; active high.
- rst_stage_o  out  N_STAGES  downstream resets, active high; bit 0 is released first.
- ready_o  out  1  all stages released, PLL locked.
- lock_lost_o  out  1  one-cycle pulse when lock drops in RELEASE or RUN.
- retry_cnt_o  out  $clog2(MAX_RETRY+1)  retries since last successful RUN entry.
- fault_o  out  1  sticky fault flag.

Behaviour:
- Single clock domain (CLKI). The one clock and the synchronous active-high reset are fixed for this block.
- Reset (RST=1 at an edge):
  - state=PLL_RST, all counters cleared, synchronizer flops cleared.
  - pll_rst_o=1, rst_stage_o=all ones, ready_o=0, lock_lost_o=0, retry_cnt_o=0, fault_o=0.
  - RST asserted mid-operation aborts immediately to these values at the next edge.
- Lock synchronizer: 2-flop, giving lock_s, 2 cycles of latency. All decisions use lock_s only.
- PLL_RST:
  - pll_rst_o=1 for exactly PLL_RST_CYC cycles, then go to WAIT_LOCK.
  - pll_rst_o is 0 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Timer counts from 0.
  - lock_s=1 -> STABLE with stable count=1; this cycle counts as the first stable cycle.
  - Timer reaches LOCK_TIMEOUT_CYC-1 with lock_s=0 -> RETRY decision.
- STABLE:
  - Each lock_s=1 cycle increments the stable count.
  - Count reaching LOCK_STABLE_CYC -> RELEASE.
  - Any lock_s=0 -> WAIT_LOCK with the timer restarted at 0; no lock_lost_o pulse.
- RELEASE:
  - rst_stage_o[0] clears on the first RELEASE cycle.
  - rst_stage_o[k] clears STAGE_GAP_CYC cycles after rst_stage_o[k-1].
  - On the cycle the last bit clears: ready_o=1, state=RUN, retry_cnt_o cleared.
  - Released bits stay cleared.
- RUN: outputs held; lock monitored.
- Lock loss (lock_s=0) in RELEASE or RUN:
  - lock_lost_o=1 for one cycle.
  - On the next edge: rst_stage_o=all ones, ready_o=0, then RETRY decision.
- RETRY decision, evaluated in one cycle:
  - retry_cnt_o==MAX_RETRY -> FAULT.
  - Otherwise retry_cnt_o+1 and go to PLL_RST, with pll_rst_o=1 on the next cycle.
- FAULT: pll_rst_o=1, rst_stage_o=all ones, ready_o=0, fault_o=1. Exited only by RST. Lock input ignored.
- Counters: saturate-free. Widths are sized with $clog2 of the largest compare value; compares use ==, no wrap.

Optional Feature:
- Macro: PLL_LOCK_DEGLITCH_EN.
- Defined: lock loss in STABLE, RELEASE or RUN is acted on only after lock_s has been 0 for 4 consecutive cycles. Action and lock_lost_o occur on the 4th low cycle. Shorter dips are ignored and do not reset the STABLE count.
- Undefined: a single lock_s=0 cycle acts immediately, as above.

Test Plan (PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, N_STAGES=3, STAGE_GAP_CYC=2, MAX_RETRY=2, macro undefined):
- Reset then lock high from cycle 10 -> pll_rst_o high cycles 0-3; STABLE entered at cycle 12; rst_stage_o steps 111->110->100->000 two cycles apart; ready_o=1 with the 000 value; retry_cnt_o=0.
- Lock never asserts -> pll_rst_o pulses 4 cycles wide, 3 attempts total; retry_cnt_o 0->1->2; then fault_o=1 and pll_rst_o stuck at 1; RST clears all.
- Lock drops for 1 cycle in RUN -> one lock_lost_o pulse, rst_stage_o=111, ready_o=0, retry_cnt_o=1, new PLL_RST of 4 cycles; re-lock -> RUN again with retry_cnt_o=0.
- Lock drops at stable count 5 -> back to WAIT_LOCK, no lock_lost_o; release occurs only after a fresh 8-cycle stable run.
- RST asserted during RELEASE with rst_stage_o=100 -> next edge all outputs at reset values.
- Macro defined: a 3-cycle lock dip in RUN -> no reaction; a 4-cycle dip -> lock_lost_o on the 4th low cycle.
